multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle RISC-V control FSM: the next-generation main controller for the RV32I subset (R-type, OP-IMM, load, store, branch, jal, jalr). It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives Moore-style datapath controls. It waits on a memory ready handshake with an optional timeout, and flags illegal opcodes. It sits between the instruction register (opcode source) and the shared-memory multi-cycle datapath.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles on `mem_ready` before error; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  rising-edge clock; only clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0]; sampled in DECODE only.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Branch, Jump  out  1 each  datapath enables/flags.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemtoReg  out  2  writeback select: 00=ALUOut, 01=MDR, 10=OldPC+4.
- ALUSrcA  out  2  ALU A select: 00=PC, 01=rs1, 10=OldPC.
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=const 4, 10=imm.
- ALUOp  out  2  00=add, 01=branch compare, 10=funct decode, 11=jump add.
- PCSource  out  2  00=ALU result, 01=ALUOut.
- error  out  1  sticky error flag.
- err_code  out  2  01=illegal opcode, 10=memory timeout.
- retire  out  1  one-cycle pulse per completed instruction.
- instr_count  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, ERROR.
- Outputs are decoded from the state only. Any output not listed for a state is 0.
- FETCH
  - Drives MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal `mem_ready`.
  - Goes to DECODE when `mem_ready`=1.
- DECODE
  - Drives ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch/jal target into ALUOut).
  - Latches `opcode` into op_q.
  - Next state by opcode: 0110011→EXEC_R; 0010011→EXEC_I; 0000011 or 0100011→MEM_ADDR; 1100011→BRANCH; 1101111→JAL; 1100111→JALR.
  - Any other opcode → ERROR with err_code=01.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Goes to MEM_READ if op_q is a load, else MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Goes to MEM_WB on `mem_ready`.
- MEM_WB: RegWrite=1, MemtoReg=01. Goes to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Goes to FETCH on `mem_ready`.
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Goes to ALU_WB.
- EXEC_I: as EXEC_R but ALUSrcB=10. Goes to ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=00. Goes to FETCH.
- BRANCH
  - Drives ALUSrcA=01, ALUSrcB=00, ALUOp=01, Branch=1, PCSource=01. Goes to FETCH.
  - The datapath writes PC only when Branch and the compare result are both true.
- JAL: PCWrite=1, PCSource=01, RegWrite=1, MemtoReg=10, Jump=1. Goes to FETCH.
- JALR: ALUSrcA=01, ALUSrcB=10, ALUOp=11, PCWrite=1, PCSource=00, RegWrite=1, MemtoReg=10, Jump=1. Goes to FETCH.
- Wait counter
  - Increments in FETCH, MEM_READ and MEM_WRITE while `mem_ready`=0. Clears on any state change.
  - When the counter reaches MEM_TIMEOUT (and MEM_TIMEOUT≠0) with `mem_ready` still 0, the next state is ERROR with err_code=10.
  - `mem_ready`=1 in the same cycle the counter reaches MEM_TIMEOUT completes normally; no error.
- ERROR: all control outputs 0; error=1. Leaves ERROR only on reset.
- retire: asserted for one cycle on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JAL or JALR. instr_count increments in that same edge.

## Timing
- Reset value of every output is 0, including MemRead; state resets to FETCH. op_q, the wait counter, error, err_code and instr_count all reset to 0.
- Reset asserted mid-instruction aborts it next edge: no retire, and no write enables during the reset cycle.
- CPI with zero wait (`mem_ready` already high): R/I=4, load=5, store=4, branch=3, jal=3, jalr=3. Each wait cycle adds 1.
- `mem_ready` is sampled only in FETCH, MEM_READ and MEM_WRITE. It is ignored in all other states.
- instr_count rolls over from 2^CNT_W−1 to 0 without flagging.

## Structure
- control_pkg holds:
  - opcode constants;
  - the state enum (4-bit);
  - ALUOp, ALUSrcA/B, MemtoReg and PCSource encodings;
  - err_code values.
- One sub-module, mem_wait_timer, is natural: it holds the wait counter and timeout compare, with its width derived from MEM_TIMEOUT.

## Test plan
- R-type 0110011 with `mem_ready`=1 → states FETCH, DECODE, EXEC_R, ALU_WB; RegWrite=1 on cycle 4 only; retire=1; instr_count 0→1.
- Load 0000011 with `mem_ready` low for 3 cycles in MEM_READ → load takes 8 cycles; MemtoReg=01 in MEM_WB; IorD=1 only in MEM_READ.
- Opcode 0000000 in DECODE → ERROR next cycle; error=1, err_code=01; outputs stay 0 for 20 cycles; reset returns to FETCH.
- MEM_TIMEOUT=4 with `mem_ready` held 0 in FETCH → ERROR entered after the 4th wait cycle, err_code=10. The same test with `mem_ready`=1 on that cycle → DECODE, no error.
- jal, then branch, then jalr → each 3 cycles. JAL: PCSource=01, MemtoReg=10. JALR: PCSource=00, ALUOp=11. BRANCH: Branch=1, ALUOp=01.
- Reset asserted in MEM_WRITE with `mem_ready`=1 → MemWrite=0 that cycle, no retire, FETCH next; with CNT_W=4, 16 retirements wrap instr_count to 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
//   Shared constants for the multi-cycle RV32I main controller: opcodes,
//   state encoding, datapath select encodings, error codes and the packed
//   control-word struct driven toward the datapath.
package multicycle_control_pkg;

    // RV32I major opcodes handled by the controller
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // State encoding (4-bit)
    typedef logic [3:0] state_t;
    localparam state_t ST_FETCH     = 4'd0;
    localparam state_t ST_DECODE    = 4'd1;
    localparam state_t ST_MEM_ADDR  = 4'd2;
    localparam state_t ST_MEM_READ  = 4'd3;
    localparam state_t ST_MEM_WB    = 4'd4;
    localparam state_t ST_MEM_WRITE = 4'd5;
    localparam state_t ST_EXEC_R    = 4'd6;
    localparam state_t ST_EXEC_I    = 4'd7;
    localparam state_t ST_ALU_WB    = 4'd8;
    localparam state_t ST_BRANCH    = 4'd9;
    localparam state_t ST_JAL       = 4'd10;
    localparam state_t ST_JALR      = 4'd11;
    localparam state_t ST_ERROR     = 4'd12;

    // ALUOp
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_JUMP  = 2'b11;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;
    localparam logic [1:0] SRCA_OLDPC  = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;

    // MemtoReg
    localparam logic [1:0] WB_ALUOUT   = 2'b00;
    localparam logic [1:0] WB_MDR      = 2'b01;
    localparam logic [1:0] WB_PC4      = 2'b10;

    // PCSource
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    // err_code
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic       iord;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Bundle between the controller and the multi-cycle datapath.
//   master: controller side (takes opcode/mem_ready, drives controls/status)
//   slave : datapath side
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             PCWrite;
    logic             IRWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             RegWrite;
    logic             Branch;
    logic             Jump;
    logic             IorD;
    logic [1:0]       MemtoReg;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             error;
    logic [1:0]       err_code;
    logic             retire;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Branch, Jump, IorD,
               MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               error, err_code, retire, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Branch, Jump, IorD,
               MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               error, err_code, retire, instr_count
    );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer
//   Counts consecutive not-ready cycles while the controller is waiting on
//   memory and flags a timeout.
//   clk, reset   : clock, synchronous active-high reset
//   i_active     : controller is in a state that waits on mem_ready
//   i_ready      : mem_ready
//   i_clear      : controller changes state this cycle
//   o_timeout    : counter already holds MEM_TIMEOUT and memory is still not ready
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    input  logic i_ready,
    input  logic i_clear,
    output logic o_timeout
);
    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] r_cnt;
    logic          w_waiting;

    assign w_waiting = i_active && !i_ready;

    // MEM_TIMEOUT full wait cycles are tolerated; a further not-ready cycle
    // with the count sitting at the limit expires. A ready in that cycle wins.
    assign o_timeout = (MEM_TIMEOUT != 0) && w_waiting && (r_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (w_waiting && (r_cnt != LIMIT)) begin
            // saturate at the limit; with MEM_TIMEOUT=0 the count stays 0
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle RV32I main controller. Sequences each instruction through
//   fetch/decode/execute/memory/writeback and drives Moore datapath controls.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master side of multicycle_control_if (opcode, mem_ready in;
//                datapath controls, error/err_code, retire, instr_count out)
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    state_t           r_state;
    state_t           w_next;
    logic [6:0]       r_op_q;
    logic             r_error;
    logic [1:0]       r_err_code;
    logic             r_retire;
    logic [CNT_W-1:0] r_count;

    logic             w_wait_state;
    logic             w_timeout;
    logic             w_retire;
    ctrl_t            w_ctrl;

    assign w_wait_state = (r_state == ST_FETCH) || (r_state == ST_MEM_READ) ||
                          (r_state == ST_MEM_WRITE);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_active  (w_wait_state),
        .i_ready   (bus.mem_ready),
        .i_clear   (w_next != r_state),
        .o_timeout (w_timeout)
    );

    // next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (bus.mem_ready)  w_next = ST_DECODE;
                else if (w_timeout) w_next = ST_ERROR;
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_R:              w_next = ST_EXEC_R;
                    OP_I:              w_next = ST_EXEC_I;
                    OP_LOAD, OP_STORE: w_next = ST_MEM_ADDR;
                    OP_BRANCH:         w_next = ST_BRANCH;
                    OP_JAL:            w_next = ST_JAL;
                    OP_JALR:           w_next = ST_JALR;
                    default:           w_next = ST_ERROR;
                endcase
            end
            ST_MEM_ADDR:  w_next = (r_op_q == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ: begin
                if (bus.mem_ready)  w_next = ST_MEM_WB;
                else if (w_timeout) w_next = ST_ERROR;
            end
            ST_MEM_WB:    w_next = ST_FETCH;
            ST_MEM_WRITE: begin
                if (bus.mem_ready)  w_next = ST_FETCH;
                else if (w_timeout) w_next = ST_ERROR;
            end
            ST_EXEC_R, ST_EXEC_I:                   w_next = ST_ALU_WB;
            ST_ALU_WB, ST_BRANCH, ST_JAL, ST_JALR:  w_next = ST_FETCH;
            ST_ERROR:                               w_next = ST_ERROR;
            default:                                w_next = ST_FETCH;
        endcase
    end

    // an instruction completes on the edge that returns to FETCH from a final state
    assign w_retire = (w_next == ST_FETCH) &&
                      ((r_state == ST_MEM_WB) || (r_state == ST_MEM_WRITE) ||
                       (r_state == ST_ALU_WB) || (r_state == ST_BRANCH) ||
                       (r_state == ST_JAL)    || (r_state == ST_JALR));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_op_q     <= '0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_retire   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state  <= w_next;
            r_retire <= w_retire;
            if (r_state == ST_DECODE) r_op_q <= bus.opcode;
            if ((r_state == ST_DECODE) && (w_next == ST_ERROR)) begin
                r_error    <= 1'b1;
                r_err_code <= ERR_ILLEGAL;
            end else if (w_timeout) begin
                r_error    <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
            end
            if (w_retire) r_count <= r_count + CNT_W'(1);
        end
    end

    // Moore control decode; FETCH's IR/PC writes follow mem_ready
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.ir_write  = bus.mem_ready;
                w_ctrl.pc_write  = bus.mem_ready;
                w_ctrl.iord      = 1'b0;
                w_ctrl.alu_src_a = SRCA_PC;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = WB_MDR;
            end
            ST_MEM_WRITE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
            end
            ST_EXEC_R, ST_EXEC_I: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = (r_state == ST_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALU_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = WB_ALUOUT;
            end
            ST_BRANCH: begin
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_RS2;
                w_ctrl.alu_op    = ALUOP_BR;
                w_ctrl.branch    = 1'b1;
                w_ctrl.pc_source = PCSRC_ALUOUT;
            end
            ST_JAL: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = PCSRC_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = WB_PC4;
                w_ctrl.jump       = 1'b1;
            end
            ST_JALR: begin
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.alu_op     = ALUOP_JUMP;
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = PCSRC_ALU;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = WB_PC4;
                w_ctrl.jump       = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
        // nothing reaches the datapath while reset is held, so an aborted
        // instruction cannot commit a write in the reset cycle
        if (reset) w_ctrl = '0;
    end

    assign bus.PCWrite     = w_ctrl.pc_write;
    assign bus.IRWrite     = w_ctrl.ir_write;
    assign bus.MemRead     = w_ctrl.mem_read;
    assign bus.MemWrite    = w_ctrl.mem_write;
    assign bus.RegWrite    = w_ctrl.reg_write;
    assign bus.Branch      = w_ctrl.branch;
    assign bus.Jump        = w_ctrl.jump;
    assign bus.IorD        = w_ctrl.iord;
    assign bus.MemtoReg    = w_ctrl.mem_to_reg;
    assign bus.ALUSrcA     = w_ctrl.alu_src_a;
    assign bus.ALUSrcB     = w_ctrl.alu_src_b;
    assign bus.ALUOp       = w_ctrl.alu_op;
    assign bus.PCSource    = w_ctrl.pc_source;
    assign bus.error       = r_error & ~reset;
    assign bus.err_code    = reset ? ERR_NONE : r_err_code;
    assign bus.retire      = r_retire & ~reset;
    assign bus.instr_count = reset ? '0 : r_count;
endmodule
